// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial memory controller between the CPU core and an 8-bit synchronous RAM.
//
// Two request ports share the RAM: instruction fetch (if_*) and data load/store (mem_*).
// A data request wins when both arrive in the same idle cycle. Each 1/2/4-byte access is
// split into consecutive RAM byte cycles, and the result is reassembled little-endian.
//
// Optional feature macro: MEMCTRL_ALIGN_CHECK_EN. When it is defined, a misaligned
// 2- or 4-byte request completes at once with err_o set and no RAM cycle. When it is
// undefined, err_o is always 0.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   if_req_i        fetch request, sampled only while idle
//   if_addr_i       fetch byte address
//   flush_i         aborts an in-flight fetch
//   if_inst_o       fetched instruction, valid with if_done_o
//   if_done_o       one-cycle fetch completion pulse
//   mem_req_i       data request, sampled only while idle
//   mem_we_i        1 = store, 0 = load
//   mem_len_i       0 = 1 byte, 1 = 2 bytes, 2/3 = 4 bytes
//   mem_addr_i      data byte address
//   mem_wdata_i     store data, low byte first
//   mem_rdata_o     load data, zero-extended, valid with mem_done_o
//   mem_done_o      one-cycle data completion pulse
//   err_o           misalignment flag, qualified by a done pulse
//   mem_busy        high whenever the controller is not idle
//   ram_addr_o      RAM byte address
//   ram_we_o        RAM write enable
//   ram_dout_o      RAM write byte
//   ram_din_i       RAM read byte, valid the cycle after its address
module mem_ctrl #(
  parameter int unsigned RAM_AW = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [31:0]       if_addr_i,
  input  logic              flush_i,
  output logic [31:0]       if_inst_o,
  output logic              if_done_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [1:0]        mem_len_i,
  input  logic [31:0]       mem_addr_i,
  input  logic [31:0]       mem_wdata_i,
  output logic [31:0]       mem_rdata_o,
  output logic              mem_done_o,
  output logic              err_o,
  output logic              mem_busy,
  output logic [RAM_AW-1:0] ram_addr_o,
  output logic              ram_we_o,
  output logic [7:0]        ram_dout_o,
  input  logic [7:0]        ram_din_i
);

  typedef enum logic [1:0] {StIdle, StRd, StWr} state_e;

  state_e state_q, state_d;

  // Transaction context latched on acceptance
  logic [RAM_AW-1:0] base_q, base_d;
  logic [1:0]        nm1_q, nm1_d;        // byte count minus one (0, 1 or 3)
  logic [2:0]        cnt_q, cnt_d;        // cycles spent in RD/WR so far
  logic [31:0]       wdata_q, wdata_d;
  logic              port_data_q, port_data_d;
  logic [31:0]       asm_q, asm_d;

  // Registered outputs
  logic [31:0]       if_inst_q, if_inst_d;
  logic              if_done_q, if_done_d;
  logic [31:0]       mem_rdata_q, mem_rdata_d;
  logic              mem_done_q, mem_done_d;
  logic              err_q, err_d;
  logic [RAM_AW-1:0] ram_addr_q, ram_addr_d;
  logic              ram_we_q, ram_we_d;
  logic [7:0]        ram_dout_q, ram_dout_d;

  // Request arbitration: data port has priority
  logic        sel_data;
  logic        req_go;
  logic [31:0] req_addr;
  logic [1:0]  mem_nm1;
  logic [1:0]  req_nm1;
  logic        misalign;

  assign sel_data = mem_req_i;
  assign req_go   = mem_req_i | if_req_i;
  assign req_addr = sel_data ? mem_addr_i : if_addr_i;
  assign mem_nm1  = (mem_len_i == 2'd0) ? 2'd0 : (mem_len_i == 2'd1) ? 2'd1 : 2'd3;
  assign req_nm1  = sel_data ? mem_nm1 : 2'd3;

`ifdef MEMCTRL_ALIGN_CHECK_EN
  assign misalign = ((req_nm1 == 2'd3) && (req_addr[1:0] != 2'd0)) ||
                    ((req_nm1 == 2'd1) && req_addr[0]);
`else
  assign misalign = 1'b0;
`endif

  // Only the low RAM_AW address bits reach the RAM
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:RAM_AW];

  logic              fetch_flush;
  logic              rd_last;
  logic              wr_last;
  logic [2:0]        cnt_inc;
  logic [RAM_AW-1:0] addr_next;
  logic [1:0]        lane;
  logic [31:0]       asm_cap;

  assign fetch_flush = !port_data_q && flush_i;
  // RD lasts N+1 cycles: N address cycles plus one for the final capture
  assign rd_last     = (cnt_q == ({1'b0, nm1_q} + 3'd1));
  assign wr_last     = (cnt_q[1:0] == nm1_q);
  assign cnt_inc     = cnt_q + 3'd1;
  assign addr_next   = base_q + RAM_AW'(cnt_inc);
  // Data on ram_din_i belongs to the address issued one cycle earlier
  assign lane        = cnt_q[1:0] - 2'd1;

  always_comb begin
    asm_cap = asm_q;
    asm_cap[{lane, 3'b000} +: 8] = ram_din_i;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (req_go && !misalign) begin
          state_d = (sel_data && mem_we_i) ? StWr : StRd;
        end
      end
      StRd: begin
        if (fetch_flush || rd_last) begin
          state_d = StIdle;
        end
      end
      StWr: begin
        if (wr_last) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output and datapath next-state logic
  always_comb begin
    base_d      = base_q;
    nm1_d       = nm1_q;
    cnt_d       = cnt_q;
    wdata_d     = wdata_q;
    port_data_d = port_data_q;
    asm_d       = asm_q;
    if_inst_d   = if_inst_q;
    if_done_d   = 1'b0;
    mem_rdata_d = mem_rdata_q;
    mem_done_d  = 1'b0;
    err_d       = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_we_d    = 1'b0;
    ram_dout_d  = ram_dout_q;

    unique case (state_q)
      StIdle: begin
        if (req_go) begin
          base_d      = req_addr[RAM_AW-1:0];
          nm1_d       = req_nm1;
          cnt_d       = 3'd0;
          wdata_d     = mem_wdata_i;
          port_data_d = sel_data;
          asm_d       = 32'd0;
          if (misalign) begin
            err_d = 1'b1;
            if (sel_data) begin
              mem_done_d  = 1'b1;
              mem_rdata_d = 32'd0;
            end else begin
              if_done_d = 1'b1;
              if_inst_d = 32'd0;
            end
          end else begin
            ram_addr_d = req_addr[RAM_AW-1:0];
            if (sel_data && mem_we_i) begin
              ram_we_d   = 1'b1;
              ram_dout_d = mem_wdata_i[7:0];
            end
          end
        end
      end
      StRd: begin
        cnt_d = cnt_inc;
        if (cnt_q != 3'd0) begin
          asm_d = asm_cap;
        end
        if (cnt_q < {1'b0, nm1_q}) begin
          ram_addr_d = addr_next;
        end
        if (!fetch_flush && rd_last) begin
          if (port_data_q) begin
            mem_done_d  = 1'b1;
            mem_rdata_d = asm_cap;
          end else begin
            if_done_d = 1'b1;
            if_inst_d = asm_cap;
          end
        end
      end
      StWr: begin
        if (wr_last) begin
          mem_done_d = 1'b1;
        end else begin
          cnt_d      = cnt_inc;
          ram_we_d   = 1'b1;
          ram_addr_d = addr_next;
          ram_dout_d = wdata_q[{cnt_inc[1:0], 3'b000} +: 8];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base_q      <= '0;
      nm1_q       <= '0;
      cnt_q       <= '0;
      wdata_q     <= '0;
      port_data_q <= 1'b0;
      asm_q       <= '0;
      if_inst_q   <= '0;
      if_done_q   <= 1'b0;
      mem_rdata_q <= '0;
      mem_done_q  <= 1'b0;
      err_q       <= 1'b0;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_dout_q  <= '0;
    end else begin
      base_q      <= base_d;
      nm1_q       <= nm1_d;
      cnt_q       <= cnt_d;
      wdata_q     <= wdata_d;
      port_data_q <= port_data_d;
      asm_q       <= asm_d;
      if_inst_q   <= if_inst_d;
      if_done_q   <= if_done_d;
      mem_rdata_q <= mem_rdata_d;
      mem_done_q  <= mem_done_d;
      err_q       <= err_d;
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      ram_dout_q  <= ram_dout_d;
    end
  end

  assign if_inst_o   = if_inst_q;
  assign if_done_o   = if_done_q;
  assign mem_rdata_o = mem_rdata_q;
  assign mem_done_o  = mem_done_q;
  assign err_o       = err_q;
  assign ram_addr_o  = ram_addr_q;
  assign ram_we_o    = ram_we_q;
  assign ram_dout_o  = ram_dout_q;
  assign mem_busy    = (state_q != StIdle);

endmodule

// File: tb/tb_mem_ctrl.sv
module tb_mem_ctrl;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        flush;
  logic [31:0] if_inst;
  logic        if_done;
  logic        mem_req;
  logic        mem_we;
  logic [1:0]  mem_len;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_done;
  logic        err;
  logic        mem_busy;
  logic [16:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_dout;
  logic [7:0]  ram_din;

  int checks;
  int failures;

  mem_ctrl #(.RAM_AW(17)) dut (
    .clk         (clk),
    .rst         (rst),
    .if_req_i    (if_req),
    .if_addr_i   (if_addr),
    .flush_i     (flush),
    .if_inst_o   (if_inst),
    .if_done_o   (if_done),
    .mem_req_i   (mem_req),
    .mem_we_i    (mem_we),
    .mem_len_i   (mem_len),
    .mem_addr_i  (mem_addr),
    .mem_wdata_i (mem_wdata),
    .mem_rdata_o (mem_rdata),
    .mem_done_o  (mem_done),
    .err_o       (err),
    .mem_busy    (mem_busy),
    .ram_addr_o  (ram_addr),
    .ram_we_o    (ram_we),
    .ram_dout_o  (ram_dout),
    .ram_din_i   (ram_din)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous byte RAM with a side port for preloading
  logic [7:0]  ram [0:131071];
  logic        tb_we;
  logic [16:0] tb_addr;
  logic [7:0]  tb_data;
  int          wr_cnt;

  initial wr_cnt = 0;

  always @(posedge clk) begin
    if (ram_we) begin
      ram[ram_addr] <= ram_dout;
      wr_cnt <= wr_cnt + 1;
    end else if (tb_we) begin
      ram[tb_addr] <= tb_data;
    end
    ram_din <= ram[ram_addr];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [16:0] a, input logic [7:0] d);
    tb_we = 1'b1;
    tb_addr = a;
    tb_data = d;
    step();
    tb_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++; if (mem_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", mem_busy); end
    checks++; if ({if_done, mem_done, err, ram_we} !== 4'b0) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {if_done, mem_done, err, ram_we}); end
    checks++; if ({if_inst, mem_rdata} !== 64'd0) begin failures++; $display("FAIL reset_data got=%h exp=0", {if_inst, mem_rdata}); end
    checks++; if ({ram_addr, ram_dout} !== 25'd0) begin failures++; $display("FAIL reset_ram got=%h exp=0", {ram_addr, ram_dout}); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_fetch();
    if_req = 1'b1;
    if_addr = 32'h100;
    step();
    if_req = 1'b0;
    checks++; if (ram_addr !== 17'h100) begin failures++; $display("FAIL fetch_addr0 got=%h exp=100", ram_addr); end
    for (int j = 1; j <= 5; j++) begin
      checks++; if (mem_busy !== 1'b1 || if_done !== 1'b0) begin failures++; $display("FAIL fetch_busy_c%0d got=%b%b exp=10", j, mem_busy, if_done); end
      step();
    end
    checks++; if (if_done !== 1'b1) begin failures++; $display("FAIL fetch_done got=%b exp=1", if_done); end
    checks++; if (if_inst !== 32'h00A00513) begin failures++; $display("FAIL fetch_inst got=%h exp=00a00513", if_inst); end
    checks++; if (mem_busy !== 1'b0) begin failures++; $display("FAIL fetch_idle got=%b exp=0", mem_busy); end
    step();
    checks++; if (if_done !== 1'b0) begin failures++; $display("FAIL fetch_pulse_width got=%b exp=0", if_done); end
  endtask

  task automatic test_arbitration();
    int md_cyc, fd_cyc;
    logic [31:0] md_data, fd_data;
    md_cyc = 0; fd_cyc = 0; md_data = 0; fd_data = 0;
    mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'd1; mem_addr = 32'h20;
    if_req = 1'b1; if_addr = 32'h0;
    step();
    mem_req = 1'b0;
    for (int j = 1; j <= 14; j++) begin
      if (j == 5) if_req = 1'b0;
      if (mem_done && md_cyc == 0) begin md_cyc = j; md_data = mem_rdata; end
      if (if_done && fd_cyc == 0) begin fd_cyc = j; fd_data = if_inst; end
      step();
    end
    checks++; if (md_cyc !== 4) begin failures++; $display("FAIL arb_mem_cycle got=%0d exp=4", md_cyc); end
    checks++; if (md_data !== 32'h0000807F) begin failures++; $display("FAIL arb_mem_data got=%h exp=0000807f", md_data); end
    checks++; if (fd_cyc !== 10) begin failures++; $display("FAIL arb_fetch_cycle got=%0d exp=10", fd_cyc); end
    checks++; if (fd_data !== 32'h44332211) begin failures++; $display("FAIL arb_fetch_data got=%h exp=44332211", fd_data); end
  endtask

  task automatic test_store_wrap();
    int d_cyc, busy_n, w0;
    d_cyc = 0; busy_n = 0; w0 = wr_cnt;
    mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'd3; mem_addr = 32'h1FFFE; mem_wdata = 32'hDEADBEEF;
    step();
    mem_req = 1'b0; mem_we = 1'b0;
    for (int j = 1; j <= 7; j++) begin
      if (mem_busy) busy_n++;
      if (mem_done && d_cyc == 0) d_cyc = j;
      step();
    end
    checks++; if (d_cyc !== 5) begin failures++; $display("FAIL store_done_cycle got=%0d exp=5", d_cyc); end
    checks++; if (busy_n !== 4) begin failures++; $display("FAIL store_busy_cycles got=%0d exp=4", busy_n); end
    checks++; if (wr_cnt - w0 !== 4) begin failures++; $display("FAIL store_write_count got=%0d exp=4", wr_cnt - w0); end
    checks++; if ({ram[17'h1FFFE], ram[17'h1FFFF], ram[17'h0], ram[17'h1]} !== 32'hEFBEADDE)
      begin failures++; $display("FAIL store_bytes got=%h exp=efbeadde", {ram[17'h1FFFE], ram[17'h1FFFF], ram[17'h0], ram[17'h1]}); end
  endtask

  task automatic test_flush();
    int n_done, fd_cyc;
    logic [31:0] fd_data;
    n_done = 0; fd_cyc = 0; fd_data = 0;
    if_req = 1'b1; if_addr = 32'h100;
    step();
    if_req = 1'b0;
    for (int j = 1; j <= 12; j++) begin
      if (j == 3) flush = 1'b1;
      if (j == 4) begin
        flush = 1'b0;
        checks++; if (mem_busy !== 1'b0) begin failures++; $display("FAIL flush_busy got=%b exp=0", mem_busy); end
        if_req = 1'b1; if_addr = 32'h104;
      end
      if (j == 5) if_req = 1'b0;
      if (if_done) begin
        n_done++;
        if (fd_cyc == 0) begin fd_cyc = j; fd_data = if_inst; end
      end
      step();
    end
    checks++; if (n_done !== 1) begin failures++; $display("FAIL flush_pulses got=%0d exp=1", n_done); end
    checks++; if (fd_cyc !== 10) begin failures++; $display("FAIL flush_refetch_cycle got=%0d exp=10", fd_cyc); end
    checks++; if (fd_data !== 32'h00100593) begin failures++; $display("FAIL flush_refetch_data got=%h exp=00100593", fd_data); end
  endtask

  task automatic test_misaligned();
    int d_cyc;
    logic [31:0] d_data;
    logic d_err, saw_busy, saw_we;
    d_cyc = 0; d_data = 0; d_err = 0; saw_busy = 0; saw_we = 0;
    mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'd3; mem_addr = 32'h102;
    step();
    mem_req = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      if (mem_busy) saw_busy = 1'b1;
      if (ram_we) saw_we = 1'b1;
      if (mem_done && d_cyc == 0) begin d_cyc = j; d_data = mem_rdata; d_err = err; end
      step();
    end
`ifdef MEMCTRL_ALIGN_CHECK_EN
    checks++; if (d_cyc !== 1) begin failures++; $display("FAIL misalign_cycle got=%0d exp=1", d_cyc); end
    checks++; if (d_err !== 1'b1) begin failures++; $display("FAIL misalign_err got=%b exp=1", d_err); end
    checks++; if (d_data !== 32'd0) begin failures++; $display("FAIL misalign_data got=%h exp=0", d_data); end
    checks++; if (saw_busy !== 1'b0) begin failures++; $display("FAIL misalign_busy got=%b exp=0", saw_busy); end
`else
    checks++; if (d_cyc !== 6) begin failures++; $display("FAIL misalign_cycle got=%0d exp=6", d_cyc); end
    checks++; if (d_err !== 1'b0) begin failures++; $display("FAIL misalign_err got=%b exp=0", d_err); end
    checks++; if (d_data !== 32'h059300A0) begin failures++; $display("FAIL misalign_data got=%h exp=059300a0", d_data); end
    checks++; if (saw_busy !== 1'b1) begin failures++; $display("FAIL misalign_busy got=%b exp=1", saw_busy); end
`endif
    checks++; if (saw_we !== 1'b0) begin failures++; $display("FAIL misalign_we got=%b exp=0", saw_we); end
  endtask

  task automatic test_reset_mid_store();
    int w0;
    logic saw_done, saw_we;
    saw_done = 0; saw_we = 0;
    poke(17'h42, 8'hAA);
    w0 = wr_cnt;
    mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'd3; mem_addr = 32'h40; mem_wdata = 32'h04030201;
    step();
    mem_req = 1'b0; mem_we = 1'b0;
    step();
    rst = 1'b1;
    step();
    checks++; if ({mem_busy, ram_we, if_done, mem_done, err} !== 5'b0)
      begin failures++; $display("FAIL rstmid_flags got=%b exp=00000", {mem_busy, ram_we, if_done, mem_done, err}); end
    checks++; if ({if_inst, mem_rdata} !== 64'd0) begin failures++; $display("FAIL rstmid_data got=%h exp=0", {if_inst, mem_rdata}); end
    checks++; if ({ram_addr, ram_dout} !== 25'd0) begin failures++; $display("FAIL rstmid_ram got=%h exp=0", {ram_addr, ram_dout}); end
    rst = 1'b0;
    for (int j = 0; j < 5; j++) begin
      if (mem_done || if_done) saw_done = 1'b1;
      if (ram_we) saw_we = 1'b1;
      step();
    end
    checks++; if ({saw_done, saw_we} !== 2'b00) begin failures++; $display("FAIL rstmid_after got=%b exp=00", {saw_done, saw_we}); end
    checks++; if (wr_cnt - w0 !== 2) begin failures++; $display("FAIL rstmid_write_count got=%0d exp=2", wr_cnt - w0); end
    checks++; if ({ram[17'h40], ram[17'h41], ram[17'h42]} !== 24'h0102AA)
      begin failures++; $display("FAIL rstmid_bytes got=%h exp=0102aa", {ram[17'h40], ram[17'h41], ram[17'h42]}); end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; if_req = 0; if_addr = 0; flush = 0; mem_req = 0; mem_we = 0;
    mem_len = 0; mem_addr = 0; mem_wdata = 0; tb_we = 0; tb_addr = 0; tb_data = 0;
    test_reset();
    poke(17'h100, 8'h13); poke(17'h101, 8'h05); poke(17'h102, 8'hA0); poke(17'h103, 8'h00);
    poke(17'h104, 8'h93); poke(17'h105, 8'h05); poke(17'h106, 8'h10); poke(17'h107, 8'h00);
    poke(17'h0, 8'h11); poke(17'h1, 8'h22); poke(17'h2, 8'h33); poke(17'h3, 8'h44);
    poke(17'h20, 8'h7F); poke(17'h21, 8'h80);
    test_fetch();
    test_arbitration();
    test_store_wrap();
    test_flush();
    test_misaligned();
    test_reset_mid_store();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
